seg7_scan_ctrl: RTL and testbench

Parametrised time-multiplexed 7-segment display controller: the sequential successor to the single-digit hex decoder with scan select. It holds a DIGITS-wide hex value and per-digit decimal points, and cycles a digit index at a programmable refresh rate. Each slot drives the decoded segment pattern plus one-hot and binary digit selects. Sits between the datapath (writes values via `load`) and the board's common-anode/cathode display pins.

---
 rtl/seg7_pkg.sv | 12 +
 rtl/seg7_scan_ctrl_if.sv | 23 ++
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 73 +++++++
 tb/tb_seg7_scan_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: hex-to-segment table and helpers shared by the scan controller.
package seg7_pkg;
    localparam logic [7:0] SEG_OFF = 8'h00;
    // Active-high gfedcba patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: datapath-side inputs and display-side outputs of the scan controller.
interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 4,
    parameter int SEL_W  = 2
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   num;
    logic [DIGITS-1:0]     dp;
    logic                  blank_lz;
    logic [7:0]            numl_seg7;
    logic [SEL_W-1:0]      numl_scan_select;
    logic [DIGITS-1:0]     digit_en;
    logic                  frame_done;
    modport master (
        output en, load, num, dp, blank_lz,
        input  numl_seg7, numl_scan_select, digit_en, frame_done
    );
    modport slave (
        input  en, load, num, dp, blank_lz,
        output numl_seg7, numl_scan_select, digit_en, frame_done
    );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: one nibble plus decimal point to an active-high {dp,gfedcba} pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);
    assign seg = blank ? SEG_OFF : {dp, hex_to_seg7(nib)};
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: double-buffered, time-multiplexed 7-segment display scanner
// with leading-zero blanking and registered pin outputs.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SEL_W          = 2,
    parameter int PRESCALE       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input logic              clk,
    input logic              rst,
    seg7_scan_ctrl_if.slave  bus
);
    localparam int PW = $clog2(PRESCALE);
    logic [PW-1:0]         presc;
    logic [SEL_W-1:0]      idx;
    logic [4*DIGITS-1:0]   act_num, sh_num, hi;
    logic [DIGITS-1:0]     act_dp, sh_dp;
    logic                  act_blz, sh_blz, pending;
    logic                  tc, wrap, blank;
    logic [7:0]            seg;
    assign tc    = bus.en && presc == PW'(PRESCALE - 1);
    assign wrap  = tc && idx == SEL_W'(DIGITS - 1);
    // A digit is a leading zero when it and every nibble above it are zero.
    assign hi    = act_num >> {idx, 2'b00};
    assign blank = act_blz && idx != '0 && hi == '0;
    seg7_decode u_dec (
        .nib   (act_num[4*idx +: 4]),
        .dp    (act_dp[idx]),
        .blank (blank),
        .seg   (seg)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            presc                <= '0;
            idx                  <= '0;
            act_num              <= '0;
            act_dp               <= '0;
            act_blz              <= 1'b0;
            sh_num               <= '0;
            sh_dp                <= '0;
            sh_blz               <= 1'b0;
            pending              <= 1'b0;
            bus.numl_seg7        <= SEG_OFF ^ {8{SEG_ACTIVE_LOW != 0}};
            bus.digit_en         <= {DIGITS{SEL_ACTIVE_LOW != 0}};
            bus.numl_scan_select <= '0;
            bus.frame_done       <= 1'b0;
        end else begin
            if (bus.en) presc <= tc ? '0 : presc + 1'b1;
            if (tc) idx <= wrap ? '0 : idx + 1'b1;
            // Active data only changes at the frame boundary; a load on that
            // very cycle bypasses the shadow copy.
            if (wrap && (bus.load || pending)) begin
                act_num <= bus.load ? bus.num : sh_num;
                act_dp  <= bus.load ? bus.dp : sh_dp;
                act_blz <= bus.load ? bus.blank_lz : sh_blz;
                pending <= 1'b0;
            end
            if (bus.load) begin
                sh_num  <= bus.num;
                sh_dp   <= bus.dp;
                sh_blz  <= bus.blank_lz;
                pending <= !wrap;
            end
            bus.numl_seg7        <= (bus.en ? seg : SEG_OFF) ^ {8{SEG_ACTIVE_LOW != 0}};
            bus.digit_en         <= (bus.en ? DIGITS'(1) << idx : '0) ^ {DIGITS{SEL_ACTIVE_LOW != 0}};
            bus.numl_scan_select <= idx;
            bus.frame_done       <= wrap;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: table vectors, corner sequences and random traffic
// checked against a time-based reference model of the scanner.
module tb_seg7_scan_ctrl;
    localparam int D = 4;
    localparam int P = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    seg7_scan_ctrl_if #(.DIGITS(D), .SEL_W(2)) bus ();
    seg7_scan_ctrl #(
        .DIGITS(D), .SEL_W(2), .PRESCALE(P), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    int vectors = 0;
    int miscompares = 0;
    logic [6:0] segtab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    // Model state: t counts enabled cycles since reset, so the lit digit and
    // the frame boundary follow directly from division.
    int t;
    logic [15:0] a_num, s_num;
    logic [3:0]  a_dp, s_dp;
    logic        a_blz, s_blz, pend;
    logic [7:0]  e_seg;
    logic [1:0]  e_sel;
    logic [3:0]  e_den;
    logic        e_fd;
    typedef struct {
        logic [15:0] num;
        logic [3:0]  dp;
        logic        blz;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [7];

    function automatic logic [7:0] pat(logic [15:0] v, logic [3:0] d, logic b, int k);
        logic [15:0] upper;
        upper = v >> (4 * k);
        if (b && k != 0 && upper == 16'h0) return 8'hFF;
        return ~{d[k], segtab[upper[3:0]]};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        int k;
        bit w;
        @(posedge clk);
        if (rst) begin
            t = 0; a_num = 0; s_num = 0; a_dp = 0; s_dp = 0;
            a_blz = 0; s_blz = 0; pend = 0;
            e_seg = 8'hFF; e_sel = 2'd0; e_den = 4'hF; e_fd = 1'b0;
        end else begin
            k = (t / P) % D;
            w = bus.en && (t % (D * P)) == D * P - 1;
            e_seg = bus.en ? pat(a_num, a_dp, a_blz, k) : 8'hFF;
            e_den = bus.en ? ~(4'b0001 << k) : 4'hF;
            e_sel = 2'(k);
            e_fd  = w;
            if (w && (bus.load || pend)) begin
                if (bus.load) begin
                    a_num = bus.num; a_dp = bus.dp; a_blz = bus.blank_lz;
                end else begin
                    a_num = s_num; a_dp = s_dp; a_blz = s_blz;
                end
                pend = 1'b0;
            end
            if (bus.load) begin
                s_num = bus.num; s_dp = bus.dp; s_blz = bus.blank_lz; pend = !w;
            end
            if (bus.en) t++;
        end
        #1;
        check("cycle", {8'h0, bus.numl_seg7, 2'b0, bus.numl_scan_select, bus.digit_en, 3'b0, bus.frame_done},
                       {8'h0, e_seg, 2'b0, e_sel, e_den, 3'b0, e_fd});
    endtask

    task automatic set_in(logic en, logic load, logic [15:0] num, logic [3:0] dp, logic blz);
        bus.en = en; bus.load = load; bus.num = num; bus.dp = dp; bus.blank_lz = blz;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        set_in(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        tick;
        check("reset_state", {19'h0, bus.numl_seg7, bus.digit_en, bus.numl_scan_select, bus.frame_done},
                             {19'h0, 8'hFF, 4'hF, 2'b00, 1'b0});
        tick;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        bit found;
        tbl[0] = '{16'h0000, 4'b0000, 1'b0, 32'hC0C0C0C0};
        tbl[1] = '{16'h12AF, 4'b0100, 1'b0, 32'hF924888E};
        tbl[2] = '{16'h0005, 4'b0000, 1'b1, 32'hFFFFFF92};
        tbl[3] = '{16'h0000, 4'b0000, 1'b1, 32'hFFFFFFC0};
        tbl[4] = '{16'h8888, 4'b0000, 1'b0, 32'h80808080};
        tbl[5] = '{16'h0005, 4'b1111, 1'b1, 32'hFFFFFF12};
        tbl[6] = '{16'h0100, 4'b0000, 1'b1, 32'hFFF9C0C0};
        set_in(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        // First frame_done lands DIGITS*PRESCALE cycles after reset release.
        do_reset;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (bus.frame_done) begin n = i; break; end
        end
        check("first_frame_done_cycle", n, D * P);
        for (int i = 0; i < 7; i++) begin
            do_reset;
            set_in(1'b1, 1'b1, tbl[i].num, tbl[i].dp, tbl[i].blz);
            tick;
            bus.load = 1'b0;
            found = 0;
            for (int c = 0; c < 20; c++) begin
                tick;
                if (bus.frame_done) begin found = 1; break; end
            end
            check("tbl_frame_done", 32'(found), 32'd1);
            for (int k = 0; k < D; k++) begin
                tick;
                check($sformatf("tbl%0d_digit%0d", i, k), {20'h0, bus.numl_seg7, bus.digit_en},
                      {20'h0, tbl[i].exp[8*k +: 8], ~(4'b0001 << k)});
                tick;
            end
        end
        // Load exactly on the wrap cycle goes straight to active.
        do_reset;
        repeat (7) tick;
        set_in(1'b1, 1'b1, 16'h8888, 4'h0, 1'b0);
        tick;
        bus.load = 1'b0;
        check("pending_after_wrap_load", 32'(dut.pending), 32'd0);
        repeat (10) tick;
        // Pause scanning at index 2, then resume.
        do_reset;
        repeat (4) tick;
        bus.en = 1'b0;
        repeat (5) tick;
        check("en_off_hold_sel", 32'(bus.numl_scan_select), 32'd2);
        bus.en = 1'b1;
        repeat (10) tick;
        // Reset wins over a same-cycle load.
        do_reset;
        repeat (3) tick;
        rst = 1'b1;
        set_in(1'b1, 1'b1, 16'hFFFF, 4'hF, 1'b1);
        tick;
        check("rst_wins_shadow", {dut.sh_num, dut.act_num} | 32'(dut.pending), 32'd0);
        rst = 1'b0;
        bus.load = 1'b0;
        repeat (10) tick;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom % 100) == 0;
            set_in(($urandom % 8) != 0, ($urandom % 10) == 0, 16'($urandom), 4'($urandom), 1'($urandom));
            tick;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
